// File: rtl/msrh_csu_issue_ctrl_pkg.sv
// Shared types for the CSU issue controller: the slice of msrh_pkg it depends
// on (issue/wakeup records) plus the controller's own state and queue entry.
package msrh_pkg;

  localparam int CMT_ID_W     = 5;
  localparam int RNID_W       = 6;
  localparam int TGT_BUS_SIZE = 3;

  typedef enum logic [0:0] {
    GPR = 1'b0,
    FPR = 1'b1
  } reg_type_t;

  typedef struct packed {
    logic              valid;
    reg_type_t         typ;
    logic [4:0]        regidx;
    logic [RNID_W-1:0] rnid;
    logic              ready;
  } reg_rd_issue_t;

  typedef struct packed {
    logic              valid;
    reg_type_t         typ;
    logic [4:0]        regidx;
    logic [RNID_W-1:0] rnid;
  } reg_wr_issue_t;

  typedef struct packed {
    logic                valid;
    logic [CMT_ID_W-1:0] cmt_id;
    logic [31:0]         inst;
    reg_wr_issue_t       rd_reg;
    reg_rd_issue_t [1:0] rd_regs;
  } issue_t;

  typedef struct packed {
    logic              valid;
    logic [RNID_W-1:0] rd_rnid;
    reg_type_t         rd_type;
  } early_wr_t;

  typedef enum logic [1:0] {
    CSU_IDLE     = 2'd0,
    CSU_INFLIGHT = 2'd1,
    CSU_DRAIN    = 2'd2
  } csu_ctrl_state_t;

  typedef struct packed {
    issue_t issue;
    logic   rs1_ready;
  } csu_q_entry_t;

endpackage

// File: rtl/msrh_csu_issue_ctrl_if.sv
// Bus bundle between the dispatch/commit side and the CSU issue controller.
//
// Handshakes:
//   dispatch : a beat transfers on a rising edge where i_disp_valid && o_disp_ready
//              and no flush is present. A full queue additionally takes the beat in
//              the cycle its head issues, so a dispatch racing a pop is not lost.
//   issue    : o_issue_valid is a one-cycle strobe; the CSU pipe has no back-pressure.
//   done     : i_done_valid is a one-cycle strobe naming the in-flight slot one-hot.
//   flush    : i_flush_valid is a one-cycle strobe; it overrides dispatch and issue.
interface msrh_csu_issue_ctrl_if
  import msrh_pkg::*;
#(
  parameter int ENTRY_SIZE = 4,
  parameter int WAKE_SIZE  = TGT_BUS_SIZE,
  parameter int CMT_ID_W   = msrh_pkg::CMT_ID_W
);

  logic                          i_disp_valid;
  issue_t                        i_disp;
  logic                          o_disp_ready;
  early_wr_t [WAKE_SIZE-1:0]     i_wake;
  logic [CMT_ID_W-1:0]           i_oldest_cmt_id;
  logic                          o_issue_valid;
  issue_t                        o_issue;
  logic [ENTRY_SIZE-1:0]         o_issue_index;
  logic                          i_done_valid;
  logic [ENTRY_SIZE-1:0]         i_done_index_oh;
  logic                          i_flush_valid;
  logic                          o_busy;
  csu_ctrl_state_t               o_dbg_state;
  logic [$clog2(ENTRY_SIZE):0]   o_dbg_count;

  modport master (
    output i_disp_valid, i_disp, i_wake, i_oldest_cmt_id,
           i_done_valid, i_done_index_oh, i_flush_valid,
    input  o_disp_ready, o_issue_valid, o_issue, o_issue_index,
           o_busy, o_dbg_state, o_dbg_count
  );

  modport slave (
    input  i_disp_valid, i_disp, i_wake, i_oldest_cmt_id,
           i_done_valid, i_done_index_oh, i_flush_valid,
    output o_disp_ready, o_issue_valid, o_issue, o_issue_index,
           o_busy, o_dbg_state, o_dbg_count
  );

endinterface

// File: rtl/msrh_csu_issue_ctrl_wake_match.sv
// Wakeup comparator: flags when any snooped write-back bus produces the given
// physical register. Physical register 0 never matches.
module msrh_csu_wake_match
  import msrh_pkg::*;
#(
  parameter int WAKE_SIZE = TGT_BUS_SIZE
) (
  input  logic [RNID_W-1:0]       rnid,
  input  reg_type_t               rd_type,
  input  early_wr_t [WAKE_SIZE-1:0] wake,
  output logic                    hit
);

  // OR-reduce the per-bus matches
  always_comb begin
    hit = 1'b0;
    for (int w = 0; w < WAKE_SIZE; w++) begin
      if (wake[w].valid && (wake[w].rd_type == rd_type) &&
          (wake[w].rd_rnid == rnid) && (rnid != '0)) begin
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msrh_csu_issue_ctrl.sv
// In-order issue controller for the CSU pipe. Holds dispatched CSR/system ops
// in a circular queue, tracks rs1 readiness from wakeups, and issues the head
// only when it is the oldest uncommitted op and nothing else is in flight.
module msrh_csu_issue_ctrl
  import msrh_pkg::*;
#(
  parameter int ENTRY_SIZE = 4,
  parameter int WAKE_SIZE  = TGT_BUS_SIZE,
  parameter int CMT_ID_W   = msrh_pkg::CMT_ID_W
) (
  input logic                  i_clk,
  input logic                  i_reset_n,
  msrh_csu_issue_ctrl_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRY_SIZE);
  localparam int CNT_W = IDX_W + 1;

  csu_q_entry_t          r_q [ENTRY_SIZE];
  logic [IDX_W-1:0]      r_head;
  logic [IDX_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  csu_ctrl_state_t       r_state;
  csu_ctrl_state_t       w_state_next;
  logic [ENTRY_SIZE-1:0] r_inflight_idx;

  csu_q_entry_t          w_head;
  logic [CMT_ID_W-1:0]   w_head_cmt_id;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_issue_fire;
  logic                  w_disp_fire;
  logic                  w_disp_hit;
  logic                  w_disp_rs1_ready;
  logic                  w_done_match;
  logic [ENTRY_SIZE-1:0] w_issue_index;
  logic [ENTRY_SIZE-1:0] w_entry_hit;

  assign w_head        = r_q[r_head];
  assign w_head_cmt_id = CMT_ID_W'(w_head.issue.cmt_id);
  assign w_full        = (r_count == CNT_W'(ENTRY_SIZE));
  assign w_empty       = (r_count == '0);

  // Head issues only from IDLE, with rs1 available, at the commit point, and never under flush.
  assign w_issue_fire = (r_state == CSU_IDLE) && !w_empty && w_head.rs1_ready &&
                        (w_head_cmt_id == bus.i_oldest_cmt_id) && !bus.i_flush_valid;

  // Flush wins over dispatch; a full queue still takes a dispatch while its head pops.
  assign w_disp_fire = bus.i_disp_valid && !bus.i_flush_valid && (!w_full || w_issue_fire);

  assign w_issue_index = w_issue_fire ? ({{(ENTRY_SIZE-1){1'b0}}, 1'b1} << r_head) : '0;

  assign w_done_match = bus.i_done_valid && (bus.i_done_index_oh == r_inflight_idx);

  // rs1 readiness for the incoming op, including a wakeup landing in the same cycle
  msrh_csu_wake_match #(.WAKE_SIZE(WAKE_SIZE)) u_disp_wake (
    .rnid    (bus.i_disp.rd_regs[0].rnid),
    .rd_type (bus.i_disp.rd_regs[0].typ),
    .wake    (bus.i_wake),
    .hit     (w_disp_hit)
  );

  assign w_disp_rs1_ready = !bus.i_disp.rd_regs[0].valid || bus.i_disp.rd_regs[0].ready ||
                            w_disp_hit;

  for (genvar g = 0; g < ENTRY_SIZE; g++) begin : g_entry_wake
    msrh_csu_wake_match #(.WAKE_SIZE(WAKE_SIZE)) u_entry_wake (
      .rnid    (r_q[g].issue.rd_regs[0].rnid),
      .rd_type (r_q[g].issue.rd_regs[0].typ),
      .wake    (bus.i_wake),
      .hit     (w_entry_hit[g])
    );
  end

  // Queue storage: write at tail on dispatch, otherwise pick up wakeups
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        if (w_disp_fire && (r_tail == IDX_W'(i))) begin
          r_q[i].issue     <= bus.i_disp;
          r_q[i].rs1_ready <= w_disp_rs1_ready;
        end else if (w_entry_hit[i]) begin
          r_q[i].rs1_ready <= 1'b1;
        end
      end
    end
  end

  // Queue pointers and occupancy; flush empties the queue and rewinds both pointers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.i_flush_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_disp_fire) begin
        r_tail <= r_tail + IDX_W'(1);
      end
      if (w_issue_fire) begin
        r_head <= r_head + IDX_W'(1);
      end
      case ({w_disp_fire, w_issue_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Remember which slot is in the pipe so its done can be recognised
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_inflight_idx <= '0;
    end else if (w_issue_fire) begin
      r_inflight_idx <= w_issue_index;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= CSU_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a matching done always returns to IDLE, even alongside a flush
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CSU_IDLE: begin
        if (w_issue_fire) begin
          w_state_next = CSU_INFLIGHT;
        end
      end
      CSU_INFLIGHT: begin
        if (w_done_match) begin
          w_state_next = CSU_IDLE;
        end else if (bus.i_flush_valid) begin
          w_state_next = CSU_DRAIN;
        end
      end
      CSU_DRAIN: begin
        if (w_done_match) begin
          w_state_next = CSU_IDLE;
        end
      end
      default: w_state_next = CSU_IDLE;
    endcase
  end

  // Outputs: issue strobe and payload, back-pressure, busy and debug view
  always_comb begin
    bus.o_issue_valid = w_issue_fire;
    bus.o_issue       = w_head.issue;
    bus.o_issue.valid = w_issue_fire;
    bus.o_issue_index = w_issue_index;
    bus.o_disp_ready  = !w_full;
    bus.o_busy        = (r_state != CSU_IDLE) || !w_empty;
    bus.o_dbg_state   = r_state;
    bus.o_dbg_count   = r_count;
  end

  // A dispatch into a full queue with no pop would be lost
  a_disp_overflow : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (bus.i_disp_valid && !bus.i_flush_valid && w_full) |-> w_issue_fire);

  // Every done must name the op currently in the pipe
  a_done_stray : assert property (@(posedge i_clk) disable iff (!i_reset_n)
    bus.i_done_valid |-> ((r_state != CSU_IDLE) && w_done_match));

endmodule

// File: tb/tb_msrh_csu_issue_ctrl.sv
// Directed bench for the CSU issue controller: per-cycle vector tables with
// hand-computed expectations, plus an asynchronous reset check mid-flight.
module tb_msrh_csu_issue_ctrl;
  import msrh_pkg::*;

  localparam logic [1:0] S_I = 2'd0;
  localparam logic [1:0] S_F = 2'd1;
  localparam logic [1:0] S_D = 2'd2;

  typedef struct {
    logic       dv;
    logic [4:0] cid;
    logic       rr;
    logic [5:0] rn;
    logic       wv;
    logic [5:0] wrn;
    logic [4:0] old;
    logic       dnv;
    logic [3:0] dn;
    logic       fl;
    logic       e_iv;
    logic [3:0] e_idx;
    logic [4:0] e_cid;
    logic       e_dr;
    logic       e_busy;
    logic [1:0] e_st;
    logic [2:0] e_cnt;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  vec_t tbl1 [39];
  vec_t tbl2 [14];

  msrh_csu_issue_ctrl_if #(.ENTRY_SIZE(4), .WAKE_SIZE(TGT_BUS_SIZE)) bus_if ();

  msrh_csu_issue_ctrl #(.ENTRY_SIZE(4), .WAKE_SIZE(TGT_BUS_SIZE)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus_if)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    logic dv, logic [4:0] cid, logic rr, logic [5:0] rn, logic wv, logic [5:0] wrn,
    logic [4:0] old, logic dnv, logic [3:0] dn, logic fl,
    logic e_iv, logic [3:0] e_idx, logic [4:0] e_cid, logic e_dr, logic e_busy,
    logic [1:0] e_st, logic [2:0] e_cnt);
    vec_t v;
    v.dv = dv; v.cid = cid; v.rr = rr; v.rn = rn; v.wv = wv; v.wrn = wrn;
    v.old = old; v.dnv = dnv; v.dn = dn; v.fl = fl;
    v.e_iv = e_iv; v.e_idx = e_idx; v.e_cid = e_cid; v.e_dr = e_dr;
    v.e_busy = e_busy; v.e_st = e_st; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: put one vector on the bus
  task automatic drive(input vec_t v);
    issue_t    d;
    early_wr_t w;
    d = '0;
    d.valid              = v.dv;
    d.cmt_id             = v.cid;
    d.inst               = 32'h3400_1073;
    d.rd_regs[0].valid   = 1'b1;
    d.rd_regs[0].typ     = GPR;
    d.rd_regs[0].regidx  = 5'd1;
    d.rd_regs[0].rnid    = v.rn;
    d.rd_regs[0].ready   = v.rr;
    w.valid   = v.wv;
    w.rd_rnid = v.wrn;
    w.rd_type = GPR;
    bus_if.i_disp_valid    = v.dv;
    bus_if.i_disp          = d;
    bus_if.i_wake          = '0;
    bus_if.i_wake[1]       = w;
    bus_if.i_oldest_cmt_id = v.old;
    bus_if.i_done_valid    = v.dnv;
    bus_if.i_done_index_oh = v.dn;
    bus_if.i_flush_valid   = v.fl;
  endtask

  // scoreboard step: drive after the edge, compare on the falling edge
  task automatic step(input string tag, input int k, input vec_t v);
    drive(v);
    @(negedge clk);
    check($sformatf("%s[%0d] issue_valid", tag, k), 32'(bus_if.o_issue_valid), 32'(v.e_iv));
    check($sformatf("%s[%0d] issue_index", tag, k), 32'(bus_if.o_issue_index), 32'(v.e_idx));
    check($sformatf("%s[%0d] disp_ready", tag, k), 32'(bus_if.o_disp_ready), 32'(v.e_dr));
    check($sformatf("%s[%0d] busy", tag, k), 32'(bus_if.o_busy), 32'(v.e_busy));
    check($sformatf("%s[%0d] state", tag, k), 32'(bus_if.o_dbg_state), 32'(v.e_st));
    check($sformatf("%s[%0d] count", tag, k), 32'(bus_if.o_dbg_count), 32'(v.e_cnt));
    if (v.e_iv) begin
      check($sformatf("%s[%0d] issue_cmt_id", tag, k), 32'(bus_if.o_issue.cmt_id), 32'(v.e_cid));
      check($sformatf("%s[%0d] issue_field_valid", tag, k), 32'(bus_if.o_issue.valid), 32'd1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //             dv cid rr rn     wv wrn    old dnv dn fl | iv idx cid dr bsy st   cnt
    // single issue, done at t+3
    tbl1[0]  = mk(1, 5, 1, 6'h03, 0, 6'h00,  5, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    tbl1[1]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  5, 0, 0, 0,  1, 1, 5, 1, 1, S_I, 1);
    tbl1[2]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  5, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 0);
    tbl1[3]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  5, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 0);
    tbl1[4]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  5, 1, 1, 0,  0, 0, 0, 1, 1, S_F, 0);
    tbl1[5]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  5, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    // back-to-back dispatch; second issues at t+4 once oldest moves
    tbl1[6]  = mk(1, 5, 1, 6'h03, 0, 6'h00,  5, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    tbl1[7]  = mk(1, 6, 1, 6'h03, 0, 6'h00,  5, 0, 0, 0,  1, 2, 5, 1, 1, S_I, 1);
    tbl1[8]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  6, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 1);
    tbl1[9]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  6, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 1);
    tbl1[10] = mk(0, 0, 1, 6'h03, 0, 6'h00,  6, 1, 2, 0,  0, 0, 0, 1, 1, S_F, 1);
    tbl1[11] = mk(0, 0, 1, 6'h03, 0, 6'h00,  6, 0, 0, 0,  1, 4, 6, 1, 1, S_I, 1);
    tbl1[12] = mk(0, 0, 1, 6'h03, 0, 6'h00,  6, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 0);
    tbl1[13] = mk(0, 0, 1, 6'h03, 0, 6'h00,  6, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 0);
    tbl1[14] = mk(0, 0, 1, 6'h03, 0, 6'h00,  6, 1, 4, 0,  0, 0, 0, 1, 1, S_F, 0);
    tbl1[15] = mk(0, 0, 1, 6'h03, 0, 6'h00,  6, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    // rs1 not ready until wake on bus 1
    tbl1[16] = mk(1, 9, 0, 6'h12, 0, 6'h00,  9, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    tbl1[17] = mk(0, 0, 0, 6'h12, 0, 6'h00,  9, 0, 0, 0,  0, 0, 0, 1, 1, S_I, 1);
    tbl1[18] = mk(0, 0, 0, 6'h12, 1, 6'h12,  9, 0, 0, 0,  0, 0, 0, 1, 1, S_I, 1);
    tbl1[19] = mk(0, 0, 0, 6'h12, 0, 6'h00,  9, 0, 0, 0,  1, 8, 9, 1, 1, S_I, 1);
    tbl1[20] = mk(0, 0, 0, 6'h12, 0, 6'h00,  9, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 0);
    tbl1[21] = mk(0, 0, 0, 6'h12, 0, 6'h00,  9, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 0);
    tbl1[22] = mk(0, 0, 0, 6'h12, 0, 6'h00,  9, 1, 8, 0,  0, 0, 0, 1, 1, S_F, 0);
    // rnid 0 is never woken
    tbl1[23] = mk(1,10, 0, 6'h00, 0, 6'h00, 10, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    tbl1[24] = mk(0, 0, 0, 6'h00, 1, 6'h00, 10, 0, 0, 0,  0, 0, 0, 1, 1, S_I, 1);
    tbl1[25] = mk(0, 0, 0, 6'h00, 0, 6'h00, 10, 0, 0, 0,  0, 0, 0, 1, 1, S_I, 1);
    tbl1[26] = mk(0, 0, 0, 6'h00, 0, 6'h00, 10, 0, 0, 0,  0, 0, 0, 1, 1, S_I, 1);
    tbl1[27] = mk(0, 0, 0, 6'h00, 0, 6'h00, 10, 0, 0, 1,  0, 0, 0, 1, 1, S_I, 1);
    // fill to full, pop one, then dispatch + pop at full
    tbl1[28] = mk(1,11, 1, 6'h03, 0, 6'h00,  0, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    tbl1[29] = mk(1,12, 1, 6'h03, 0, 6'h00,  0, 0, 0, 0,  0, 0, 0, 1, 1, S_I, 1);
    tbl1[30] = mk(1,13, 1, 6'h03, 0, 6'h00,  0, 0, 0, 0,  0, 0, 0, 1, 1, S_I, 2);
    tbl1[31] = mk(1,14, 1, 6'h03, 0, 6'h00,  0, 0, 0, 0,  0, 0, 0, 1, 1, S_I, 3);
    tbl1[32] = mk(0, 0, 1, 6'h03, 0, 6'h00,  0, 0, 0, 0,  0, 0, 0, 0, 1, S_I, 4);
    tbl1[33] = mk(0, 0, 1, 6'h03, 0, 6'h00, 11, 0, 0, 0,  1, 1,11, 0, 1, S_I, 4);
    tbl1[34] = mk(1,15, 1, 6'h03, 0, 6'h00, 11, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 3);
    tbl1[35] = mk(0, 0, 1, 6'h03, 0, 6'h00, 11, 0, 0, 0,  0, 0, 0, 0, 1, S_F, 4);
    tbl1[36] = mk(0, 0, 1, 6'h03, 0, 6'h00, 11, 1, 1, 0,  0, 0, 0, 0, 1, S_F, 4);
    tbl1[37] = mk(1,16, 1, 6'h03, 0, 6'h00, 12, 0, 0, 0,  1, 2,12, 0, 1, S_I, 4);
    tbl1[38] = mk(0, 0, 1, 6'h03, 0, 6'h00, 12, 0, 0, 0,  0, 0, 0, 0, 1, S_F, 4);

    // after a fresh reset: flush in flight, drain, flush+done+dispatch, same-cycle wake
    tbl2[0]  = mk(1, 1, 1, 6'h03, 0, 6'h00,  1, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    tbl2[1]  = mk(1, 2, 1, 6'h03, 0, 6'h00,  1, 0, 0, 0,  1, 1, 1, 1, 1, S_I, 1);
    tbl2[2]  = mk(1, 3, 1, 6'h03, 0, 6'h00,  1, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 1);
    tbl2[3]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  1, 0, 0, 1,  0, 0, 0, 1, 1, S_F, 2);
    tbl2[4]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  1, 0, 0, 1,  0, 0, 0, 1, 1, S_D, 0);
    tbl2[5]  = mk(1, 4, 1, 6'h03, 0, 6'h00,  4, 0, 0, 0,  0, 0, 0, 1, 1, S_D, 0);
    tbl2[6]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  4, 0, 0, 0,  0, 0, 0, 1, 1, S_D, 1);
    tbl2[7]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  4, 1, 1, 0,  0, 0, 0, 1, 1, S_D, 1);
    tbl2[8]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  4, 0, 0, 0,  1, 1, 4, 1, 1, S_I, 1);
    tbl2[9]  = mk(0, 0, 1, 6'h03, 0, 6'h00,  4, 0, 0, 0,  0, 0, 0, 1, 1, S_F, 0);
    tbl2[10] = mk(1, 5, 1, 6'h03, 0, 6'h00,  5, 1, 1, 1,  0, 0, 0, 1, 1, S_F, 0);
    tbl2[11] = mk(0, 0, 1, 6'h03, 0, 6'h00,  5, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    tbl2[12] = mk(1, 6, 0, 6'h20, 1, 6'h20,  6, 0, 0, 0,  0, 0, 0, 1, 0, S_I, 0);
    tbl2[13] = mk(0, 0, 0, 6'h20, 0, 6'h00,  6, 0, 0, 0,  1, 1, 6, 1, 1, S_I, 1);

    // reset values, checked while reset is held
    rst_n = 1'b0;
    drive(mk(0, 0, 1, 6'h03, 0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0, S_I, 0));
    repeat (2) @(posedge clk);
    #1;
    check("reset issue_valid", 32'(bus_if.o_issue_valid), 32'd0);
    check("reset issue_index", 32'(bus_if.o_issue_index), 32'd0);
    check("reset disp_ready", 32'(bus_if.o_disp_ready), 32'd1);
    check("reset busy", 32'(bus_if.o_busy), 32'd0);
    check("reset state", 32'(bus_if.o_dbg_state), 32'(S_I));
    check("reset count", 32'(bus_if.o_dbg_count), 32'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 39; k++) begin
      step("t1", k, tbl1[k]);
    end

    // asynchronous reset while an op is in flight
    drive(mk(0, 0, 1, 6'h03, 0, 6'h00, 13, 0, 0, 0, 0, 0, 0, 1, 0, S_I, 0));
    #1;
    check("pre_reset busy", 32'(bus_if.o_busy), 32'd1);
    check("pre_reset state", 32'(bus_if.o_dbg_state), 32'(S_F));
    rst_n = 1'b0;
    #1;
    check("async_reset issue_valid", 32'(bus_if.o_issue_valid), 32'd0);
    check("async_reset busy", 32'(bus_if.o_busy), 32'd0);
    check("async_reset disp_ready", 32'(bus_if.o_disp_ready), 32'd1);
    check("async_reset state", 32'(bus_if.o_dbg_state), 32'(S_I));
    check("async_reset count", 32'(bus_if.o_dbg_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 14; k++) begin
      step("t2", k, tbl2[k]);
    end

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
